// File: rtl/sync_pkg.sv
// sync_pkg: shared width helpers and pipeline stage type for the sync_arbiter slice
package sync_pkg;
    localparam int TAG_MAX  = 4;
    localparam int DATA_MAX = 32;
    function automatic int width_of(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction
    function automatic int tag_w(input int num_req);
        return width_of(num_req);
    endfunction
    typedef struct packed {
        logic                valid;
        logic [TAG_MAX-1:0]  tag;
        logic [DATA_MAX-1:0] data;
    } stage_t;
endpackage

// File: rtl/sync_reg.sv
// sync_reg: resetless fixed-depth shift chain carrying tag and payload
module sync_reg #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3
) (
    input  logic             clk_d,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] stage [DEPTH];
    always_ff @(posedge clk_d) begin
        stage[0] <= d;
        for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
    assign q = stage[DEPTH-1];
endmodule

// File: rtl/sync_arbiter.sv
// sync_arbiter: round-robin grant into a shared fixed-latency delay chain
module sync_arbiter
    import sync_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int DELAY      = 3
) (
    input  logic                            clk_d,
    input  logic                            rst_n,
    input  logic                            enable_i,
    input  logic                            flush_i,
    input  logic [NUM_REQ-1:0]              req_valid_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data_i,
    output logic [NUM_REQ-1:0]              req_ready_o,
    output logic [NUM_REQ-1:0]              rsp_valid_o,
    output logic [DATA_WIDTH-1:0]           rsp_data_o,
    output logic [width_of(DELAY+1)-1:0]    inflight_o,
    output logic                            busy_o
);
    localparam int TW = tag_w(NUM_REQ);
    localparam int CW = width_of(DELAY+1);
    logic [TW-1:0]             rr_ptr, gidx;
    logic [TW:0]               sum;
    logic [2*NUM_REQ-1:0]      dbl;
    logic [NUM_REQ-1:0]        rot;
    logic                      hs;
    logic [DATA_WIDTH-1:0]     gdata;
    logic [DELAY-1:0]          vld;
    logic [TW+DATA_WIDTH-1:0]  dout;
    assign dbl = {req_valid_i, req_valid_i} >> rr_ptr;
    assign rot = dbl[NUM_REQ-1:0];
    always_comb begin
        sum = '0;
        for (int i = NUM_REQ-1; i >= 0; i--) sum = rot[i] ? {1'b0, rr_ptr} + (TW+1)'(i) : sum;
        gidx = (sum >= (TW+1)'(NUM_REQ)) ? TW'(sum - (TW+1)'(NUM_REQ)) : TW'(sum);
        hs = (|rot) & enable_i & ~flush_i & rst_n;
    end
    assign req_ready_o = hs ? NUM_REQ'(1) << gidx : '0;
    always_comb begin
        gdata = '0;
        for (int k = 0; k < NUM_REQ; k++) gdata = req_ready_o[k] ? req_data_i[k*DATA_WIDTH +: DATA_WIDTH] : gdata;
    end
    sync_reg #(.WIDTH(TW+DATA_WIDTH), .DEPTH(DELAY)) u_reg (
        .clk_d (clk_d),
        .d     ({gidx, gdata}),
        .q     (dout)
    );
    always_ff @(posedge clk_d) begin
        if (!rst_n) begin
            rr_ptr     <= '0;
            vld        <= '0;
            inflight_o <= '0;
        end else if (flush_i) begin
            vld        <= '0;
            inflight_o <= '0;
        end else begin
            vld        <= DELAY'({vld, hs});
            rr_ptr     <= hs ? ((gidx == TW'(NUM_REQ-1)) ? '0 : gidx + TW'(1)) : rr_ptr;
            inflight_o <= inflight_o + CW'(hs) - CW'(vld[DELAY-1]);
        end
    end
    assign rsp_valid_o = vld[DELAY-1] ? NUM_REQ'(1) << dout[TW+DATA_WIDTH-1 -: TW] : '0;
    assign rsp_data_o  = dout[DATA_WIDTH-1:0];
    assign busy_o      = |inflight_o;
endmodule
